// File: rtl/bcd_to_binary.sv
// bcd_to_binary: iterative reverse double-dabble of Hundreds/Tens/Ones BCD into 7-bit binary; start/busy/valid handshake, error flags bad input, dash/blank map to 7'h7F/7'h7E
module bcd_to_binary #(
  parameter int WIDTH = 7,
  parameter int ITER = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       Hundreds,
  input  logic [3:0]       Tens,
  input  logic [3:0]       Ones,
  output logic [WIDTH-1:0] binary,
  output logic             error,
  output logic             busy,
  output logic             valid
);
  localparam logic [1:0] IDLE = 2'd0, CHECK = 2'd1, SHIFT = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [11:0] dig, nxt_dig;
  logic [WIDTH-1:0] res, nxt_res;
  logic [11+WIDTH:0] sh;
  logic [2:0] cnt;
  logic err_f, dash, blank, bad;
  function automatic logic [3:0] adj(input logic [3:0] d);
    return d >= 4'd8 ? d - 4'd3 : d;
  endfunction
  always_comb begin
    sh = {dig, res} >> 1;
    nxt_res = sh[WIDTH-1:0];
    nxt_dig = {adj(sh[WIDTH+11 -: 4]), adj(sh[WIDTH+7 -: 4]), adj(sh[WIDTH+3 -: 4])};
    dash = dig == 12'haaa;
    blank = dig == 12'hbbb;
    bad = dig[11:8] > 4'd1 || dig[7:4] > 4'd9 || dig[3:0] > 4'd9 ||
          (dig[11:8] == 4'd1 && dig[7:0] > 8'h25);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      binary <= '0;
      error <= 1'b0;
      busy <= 1'b0;
      valid <= 1'b0;
      dig <= '0;
      res <= '0;
      err_f <= 1'b0;
      cnt <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dig <= {Hundreds, Tens, Ones};
          res <= '0;
          err_f <= 1'b0;
          busy <= 1'b1;
          state <= CHECK;
        end
        CHECK: begin
          if (dash || blank || bad) begin
            res <= dash ? WIDTH'(7'h7f) : blank ? WIDTH'(7'h7e) : '0;
            err_f <= !(dash || blank);
            state <= DONE;
          end else begin
            cnt <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          dig <= nxt_dig;
          res <= nxt_res;
          cnt <= cnt + 3'd1;
          if (cnt == 3'(ITER - 1)) begin
            state <= DONE;
            assert (nxt_dig == 12'd0);
          end
        end
        default: begin
          binary <= res;
          error <= err_f;
          valid <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: randomized scoreboard bench for bcd_to_binary against an arithmetic reference model
module tb_bcd_to_binary;
  logic clk = 0, rst = 1, start = 0;
  logic [3:0] hundreds = 0, tens = 0, ones = 0;
  logic [6:0] binary;
  logic error, busy, valid;
  int checks = 0, passes = 0, cyc = 0;
  typedef struct {int bin; int err; int due; int bsy;} exp_t;
  exp_t sb[$];
  int last_bin = 0, last_err = 0, busy_run = 0;
  logic prev_valid = 0;
  bcd_to_binary dut (
    .clk(clk), .rst(rst), .start(start), .Hundreds(hundreds), .Tens(tens), .Ones(ones),
    .binary(binary), .error(error), .busy(busy), .valid(valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
  endtask
  function automatic void ref_model(input int h, input int t, input int o,
                                    output int bin, output int err, output int numeric);
    int v;
    v = h * 100 + t * 10 + o;
    numeric = 0;
    bin = 0;
    err = 0;
    if (h == 10 && t == 10 && o == 10) bin = 127;
    else if (h == 11 && t == 11 && o == 11) bin = 126;
    else if (h > 1 || t > 9 || o > 9 || v > 125) err = 1;
    else begin
      bin = v;
      numeric = 1;
    end
  endfunction
  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy_run = 0;
      last_bin = 0;
      last_err = 0;
      prev_valid = 0;
    end else begin
      if (valid) begin
        chk("valid_not_consecutive", int'(prev_valid), 0);
        if (sb.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("binary", int'(binary), e.bin);
          chk("error", int'(error), e.err);
          chk("latency", cyc, e.due);
          chk("busy_cycles", busy_run, e.bsy);
        end
        last_bin = int'(binary);
        last_err = int'(error);
        busy_run = 0;
      end else begin
        chk("hold_binary", int'(binary), last_bin);
        chk("hold_error", int'(error), last_err);
        if (busy) busy_run++;
      end
      prev_valid = valid;
    end
  end
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask
  task automatic issue(input int h, input int t, input int o, input int bin, input int err, input int numeric);
    exp_t e;
    wait_idle();
    hundreds = 4'(h);
    tens = 4'(t);
    ones = 4'(o);
    start = 1;
    e.bin = bin;
    e.err = err;
    e.due = cyc + (numeric ? 10 : 3);
    e.bsy = numeric ? 9 : 2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 0;
    hundreds = 4'($urandom);
    tens = 4'($urandom);
    ones = 4'($urandom);
  endtask
  task automatic conv(input int h, input int t, input int o);
    int bin, err, numeric;
    ref_model(h, t, o, bin, err, numeric);
    issue(h, t, o, bin, err, numeric);
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0 || busy) chk("drain_timeout", 1, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("reset_binary", int'(binary), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(valid), 0);
    conv(0, 0, 0);
    conv(1, 2, 5);
    conv(0, 9, 9);
    conv(0, 6, 4);
    issue(10, 10, 10, 127, 0, 0);
    issue(11, 11, 11, 126, 0, 0);
    issue(1, 2, 6, 0, 1, 0);
    issue(2, 0, 0, 0, 1, 0);
    issue(0, 1, 12, 0, 1, 0);
    issue(10, 10, 0, 0, 1, 0);
    drain();
    issue(0, 9, 9, 99, 0, 1);
    repeat (4) @(posedge clk);
    #1;
    hundreds = 0;
    tens = 1;
    ones = 7;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    drain();
    wait_idle();
    hundreds = 0;
    tens = 8;
    ones = 8;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    chk("abort_binary", int'(binary), 0);
    chk("abort_error", int'(error), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(valid), 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    issue(0, 4, 2, 42, 0, 1);
    drain();
    for (int v = 0; v < 128; v++) begin
      if (v == 127) issue(10, 10, 10, v, 0, 0);
      else if (v == 126) issue(11, 11, 11, v, 0, 0);
      else issue(v / 100, (v / 10) % 10, v % 10, v, 0, 1);
    end
    drain();
    for (int i = 0; i < 150; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 6) begin
        int v;
        v = int'($urandom_range(0, 130));
        conv(v / 100, (v / 10) % 10, v % 10);
      end else if (sel == 6) conv(10, 10, 10);
      else if (sel == 7) conv(11, 11, 11);
      else conv(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential BCD-to-binary converter; inverse of the team's binary-to-BCD display converter.
- Takes three BCD digits (hundreds, tens, ones) from keypad/display-side logic and returns the 7-bit binary value.
- Uses iterative reverse double-dabble: one shift per clock, with a start/valid handshake.
- Recognises the two reserved display codes (dash, blank) and maps them back to their reserved binary values.

Parameters:
- WIDTH, 7, binary result width; fixed at 7 for this release. The block is verified only at 7.
- ITER, 7, shift iterations; must equal WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request conversion; sampled only in IDLE.
- Hundreds  input  4  BCD hundreds digit.
- Tens  input  4  BCD tens digit.
- Ones  input  4  BCD ones digit.
- binary  output  7  converted result; registered.
- error  output  1  result invalid; registered, qualifies binary.
- busy  output  1  high from the accepting edge until valid is issued.
- valid  output  1  one-cycle pulse; binary and error are new this cycle.

Behaviour:
- Reset, on the rising edge with rst=1, has priority over everything. Effects:
  - state=IDLE; binary=0, error=0, busy=0, valid=0.
  - In-flight conversion is aborted with no valid pulse.
- IDLE:
  - If start=1 at an edge, latch {Hundreds,Tens,Ones} into a 12-bit digit register, zero a 7-bit result shift register, set busy=1, go to CHECK.
  - Input ports are not sampled again until the next IDLE.
- CHECK (1 cycle):
  - Dash: all three latched digits = 4'b1010 -> result 7'h7F, error=0, go to DONE.
  - Blank: all three digits = 4'b1011 -> result 7'h7E, error=0, go to DONE.
  - Error: any digit > 9 (including partial dash/blank mixes), or Hundreds > 1, or decimal value > 125 -> result 7'h00, error=1, go to DONE.
  - Note: 126 and 127 are reserved for dash/blank, so 125 is the largest numeric value.
  - Otherwise: clear the iteration counter, go to SHIFT.
- SHIFT (exactly ITER=7 cycles), each cycle:
  - Shift the 19-bit concatenation {digits, result} right by 1.
  - Then, in each 4-bit BCD digit of the shifted digit field, subtract 3 if the digit is ≥ 8.
  - Increment the counter; after the 7th shift go to DONE.
  - After 7 shifts the digit field must be 0 for legal inputs. An assertion flags a nonzero field in simulation only; there is no RTL action.
- DONE (1 cycle):
  - Load binary and error from the internal result/flag; valid=1, busy=0; go to IDLE.
- Latency, counted from the edge E0 that accepts start:
  - Numeric conversion: valid high in the cycle after edge E0+9.
  - Dash/blank/error: valid high in the cycle after edge E0+2.
  - Back-to-back: start may be high in the valid cycle and is accepted at the next edge. Throughput is one numeric conversion per 10 cycles.
- start while busy=1 is ignored; no queueing.
- start held high continuously triggers a new conversion each time IDLE is reached.
- binary and error hold their last values between valid pulses; they change only in DONE or on reset.
- valid is never high for two consecutive cycles.
- Round-trip property: for every 7-bit value v, this block fed with the binary-to-BCD converter's digits for v returns v with error=0. This covers 0..125 numeric plus the 126/127 reserved codes.

Test Plan:
- Reset, then start with digits 0,0,0 -> valid after edge E0+9; binary=7'd0, error=0; busy high for 9 cycles.
- Start with digits 1,2,5 -> binary=7'd125, error=0. Then 0,9,9 -> 7'd99, and 0,6,4 -> 7'd64.
- Start with digits 1010,1010,1010 -> binary=7'h7F, error=0, valid after edge E0+2. Digits 1011,1011,1011 -> 7'h7E.
- Error inputs, each -> binary=0, error=1, 2-cycle latency:
  - 1,2,6 (value > 125);
  - 2,0,0 (hundreds > 1);
  - 0,1,12 (digit > 9);
  - 1010,1010,0000 (partial dash).
- Pulse start again during SHIFT with different digits -> ignored. Only the first result appears, and exactly one valid pulse.
- Assert rst during the 4th SHIFT cycle -> outputs 0 on the next edge and no valid. A new start with 0,4,2 then yields 7'd42.
- Exhaustive round-trip loop over v=0..127 through the binary-to-BCD converter and this block -> binary==v and error=0 for all v.
